// File: rtl/divmod_if.sv
// Operand/result bundle for the sequential divider.
// A request is taken when start=1 on a rising edge in IDLE; done pulses for one cycle when the results are valid.
interface divmod_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             busy;
    logic             done;
    logic             div0;
    logic [1:0]       dbg_state;

    modport master (
        output start, sgn, dividend, divisor,
        input  quo, rem, busy, done, div0, dbg_state
    );

    modport slave (
        input  start, sgn, dividend, divisor,
        output quo, rem, busy, done, div0, dbg_state
    );
endinterface

// File: rtl/divmod_seq.sv
// Sequential signed/unsigned divider: one non-restoring step per cycle,
// followed by remainder correction and sign fix-up.
module divmod_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    divmod_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             zero_q, zero_d;
    logic             div0_q, div0_d;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             dvs_zero;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_step;
    logic [WIDTH:0]   r_fix;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;
    logic             last_step;
    logic             fix_commit;

    // State register (all flops).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            q_q       <= q_d;
            d_q       <= d_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            zero_q    <= zero_d;
            div0_q    <= div0_d;
        end
    end

    always_comb begin
        dvd_mag    = (bus.sgn && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        dvs_mag    = (bus.sgn && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
        dvs_zero   = (bus.divisor == '0);
        d_ext      = {1'b0, d_q};
        r_sh       = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        r_step     = r_q[WIDTH] ? (r_sh + d_ext) : (r_sh - d_ext);
        r_fix      = r_q[WIDTH] ? (r_q + d_ext) : r_q;
        quo_fixed  = quo_neg_q ? -q_q : q_q;
        rem_fixed  = rem_neg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        last_step  = (cnt_q == CW'(WIDTH - 1));
        fix_commit = (cnt_q == CW'(1));
    end

    // Next-state logic. A zero divisor skips CALC and lands directly on the
    // commit phase of FIX, so it completes one edge after it was accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = dvs_zero ? FIX : CALC;
            CALC: if (last_step) state_d = FIX;
            FIX:  if (fix_commit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates. FIX spends cnt=0 on remainder correction and cnt=1
    // on committing the sign-adjusted results.
    always_comb begin
        cnt_d     = cnt_q;
        r_d       = r_q;
        q_d       = q_q;
        d_d       = d_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        zero_d    = zero_q;
        div0_d    = div0_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    r_d       = '0;
                    q_d       = dvs_zero ? bus.dividend : dvd_mag;
                    d_d       = dvs_mag;
                    quo_neg_d = bus.sgn & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    rem_neg_d = bus.sgn & bus.dividend[WIDTH-1];
                    zero_d    = dvs_zero;
                    div0_d    = 1'b0;
                    cnt_d     = dvs_zero ? CW'(1) : '0;
                end
            end
            CALC: begin
                r_d   = r_step;
                q_d   = {q_q[WIDTH-2:0], ~r_step[WIDTH]};
                cnt_d = last_step ? '0 : cnt_q + 1'b1;
            end
            FIX: begin
                if (!fix_commit) begin
                    r_d   = r_fix;
                    cnt_d = CW'(1);
                end else begin
                    cnt_d = '0;
                    if (zero_q) begin
                        quo_d  = '1;
                        rem_d  = q_q;
                        div0_d = 1'b1;
                    end else begin
                        quo_d  = quo_fixed;
                        rem_d  = rem_fixed;
                    end
                end
            end
            DONE: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        bus.quo       = quo_q;
        bus.rem       = rem_q;
        bus.div0      = div0_q;
        bus.busy      = (state_q == CALC) || (state_q == FIX);
        bus.done      = (state_q == DONE);
        bus.dbg_state = state_q;
    end
endmodule
